prime_stream_gen: RTL and testbench
===================================

Name: prime_stream_gen

Overview:
Sequential prime enumerator. On `start` it sweeps candidates 2..`limit` and tests each one by iterative trial division (repeated subtraction, no divider). It emits every prime in ascending order over a valid/ready stream. It is the source side of the prime-detect path: it produces the golden prime sequence that is_prime_* consumers and checkers compare against.

Parameters:
WIDTH, 8, bit width of candidates, `limit` and `prime_out` (must be ≥ 3).
CNT_W, 8, width of the `prime_count` output.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a sweep when idle; ignored while busy.
limit  in  WIDTH  inclusive upper bound; sampled on the accepted start.
prime_out  out  WIDTH  current prime; valid when out_valid=1.
out_valid  out  1  prime_out holds a prime.
out_ready  in  1  consumer accepts when out_valid & out_ready.
busy  out  1  sweep in progress (start accepted, done not yet asserted).
done  out  1  one-cycle pulse when the sweep completes.
prime_count  out  CNT_W  number of primes accepted in the current or last sweep; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. prime_out=0, out_valid=0, busy=0, done=0, prime_count=0. A sweep in progress is abandoned; a pending out_valid drops the next cycle with no transfer.
- States: IDLE, LOAD, DIV_INIT, SUB, TEST, EMIT, ADV, FIN.
- IDLE: start=1 latches limit into lim_q, clears prime_count, sets busy=1 and goes to LOAD. If limit<2, go straight to FIN instead.
- LOAD: candidate n=2 on the first entry; goes to DIV_INIT.
- DIV_INIT: d=2. If d*d > n (2*WIDTH-bit compare, no overflow), n is prime → EMIT. Otherwise r=n → SUB.
- SUB: while r ≥ d, r ← r−d, one subtraction per cycle. When r<d → TEST.
- TEST:
  - r==0 → composite → ADV.
  - Otherwise d←d+1 and r←n. If the new d*d > n → prime → EMIT; else → SUB.
- EMIT: prime_out=n, out_valid=1. Hold prime_out and out_valid stable until out_ready=1. The transfer cycle increments prime_count (saturating). out_valid drops the next cycle → ADV.
- ADV:
  - If n==lim_q → FIN.
  - Else n←n+1 → DIV_INIT.
  - n never wraps: the n==lim_q check precedes the increment, so lim_q=2^WIDTH−1 terminates correctly.
- FIN: done=1 for exactly one cycle, busy=0 → IDLE. prime_count holds until the next accepted start.
- start asserted in any non-IDLE state is ignored. start in the same cycle as FIN is ignored; it is accepted only when IDLE is sampled.
- out_valid is never asserted outside EMIT. There is no throughput or latency guarantee per prime, only order and completeness. Each EMIT stalls indefinitely under backpressure without losing data.
- out_ready while out_valid=0 has no effect.
- Arithmetic:
  - d fits in WIDTH bits.
  - d*d is computed at 2*WIDTH bits.
  - r and n are unsigned WIDTH bits.

Test Plan:
1. rst, then start with limit=7 and out_ready tied 1 → accepted stream 2,3,5,7, then one done pulse, prime_count=4, busy=0.
2. limit=1 (and separately limit=0) → no out_valid ever; done pulses exactly once, within 3 cycles of start; prime_count=0.
3. limit=30 with out_ready toggling pseudo-randomly → stream 2,3,5,7,11,13,17,19,23,29. prime_out is stable while out_valid & !out_ready; no duplicate or dropped values; prime_count=10.
4. limit=255 (WIDTH=8) → 54 primes, last 251. Sweep terminates (no wrap to 0); prime_count=54.
5. limit=30, out_ready=0; a second start pulse during the first EMIT → ignored. Release out_ready → the original sequence completes unchanged.
6. limit=100, assert rst while out_valid=1 holding 13 → the next cycle out_valid=0, busy=0, prime_count=0. A fresh start with limit=7 then yields 2,3,5,7.

Source files
------------

// File: rtl/prime_stream_gen.sv
// Sequential prime enumerator: sweeps 2..limit, tests each candidate by trial
// division using repeated subtraction, and streams the primes out over valid/ready.
module prime_stream_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] prime_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] prime_count
);

    // Stream handshake: prime_out/out_valid are held stable from the first
    // cycle out_valid=1 until the cycle with out_valid & out_ready, which is
    // the single transfer cycle; out_ready alone has no effect.
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DIV_INIT, S_SUB, S_TEST, S_EMIT, S_ADV, S_FIN
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]   d_inc;
    logic [2*WIDTH-1:0] n_wide;
    logic [2*WIDTH-1:0] sq_init;
    logic [2*WIDTH-1:0] sq_inc;

    // Squares are formed at double width so d*d > n never overflows.
    assign d_inc   = d_q + WIDTH'(1);
    assign n_wide  = {{WIDTH{1'b0}}, n_q};
    assign sq_init = (2*WIDTH)'(4);
    assign sq_inc  = {{WIDTH{1'b0}}, d_inc} * {{WIDTH{1'b0}}, d_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            n_q   <= '0;
            d_q   <= '0;
            r_q   <= '0;
            lim_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            n_q   <= n_d;
            d_q   <= d_d;
            r_q   <= r_d;
            lim_q <= lim_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_next = state;
        n_d        = n_q;
        d_d        = d_q;
        r_d        = r_q;
        lim_d      = lim_q;
        cnt_d      = cnt_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    lim_d      = limit;
                    cnt_d      = '0;
                    state_next = (limit < WIDTH'(2)) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                n_d        = WIDTH'(2);
                state_next = S_DIV_INIT;
            end
            S_DIV_INIT: begin
                d_d = WIDTH'(2);
                if (sq_init > n_wide) begin
                    state_next = S_EMIT;
                end else begin
                    r_d        = n_q;
                    state_next = S_SUB;
                end
            end
            S_SUB: begin
                if (r_q >= d_q) begin
                    r_d = r_q - d_q;
                end else begin
                    state_next = S_TEST;
                end
            end
            S_TEST: begin
                if (r_q == '0) begin
                    state_next = S_ADV;
                end else begin
                    d_d        = d_inc;
                    r_d        = n_q;
                    state_next = (sq_inc > n_wide) ? S_EMIT : S_SUB;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    state_next = S_ADV;
                end
            end
            S_ADV: begin
                // Compare before incrementing so a limit of all-ones never wraps n.
                if (n_q == lim_q) begin
                    state_next = S_FIN;
                end else begin
                    n_d        = n_q + WIDTH'(1);
                    state_next = S_DIV_INIT;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign out_valid   = (state == S_EMIT);
    assign prime_out   = out_valid ? n_q : '0;
    assign busy        = (state != S_IDLE) && (state != S_FIN);
    assign done        = (state == S_FIN);
    assign prime_count = cnt_q;

endmodule

// File: tb/tb_prime_stream_gen.sv
// Directed bench for prime_stream_gen: drives sweeps with various limits and
// consumer backpressure and compares the accepted stream against known lists.
module tb_prime_stream_gen;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] prime_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] prime_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int done_cnt;
    int unstable;
    int cycles_to_done;
    bit timed_out;

    prime_stream_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .limit(limit),
        .prime_out(prime_out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .prime_count(prime_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit is_prime_ref(input int v);
        if (v < 2) return 1'b0;
        for (int k = 2; k * k <= v; k++) if (v % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pulse_start(input logic [WIDTH-1:0] lim);
        @(negedge clk);
        limit = lim;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs the consumer from the current negedge until three cycles past the
    // first done pulse (or the budget expires). mode 0: ready=1, 1: random.
    task automatic collect(input int mode, input int budget);
        logic             prev_stall;
        logic [WIDTH-1:0] prev_val;
        bit               finished;
        got_q.delete();
        done_cnt = 0;
        unstable = 0;
        cycles_to_done = -1;
        prev_stall = 1'b0;
        prev_val = '0;
        finished = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (prev_stall && (out_valid !== 1'b1 || prime_out !== prev_val)) unstable++;
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (out_valid === 1'b1 && out_ready) got_q.push_back(prime_out);
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_val = prime_out;
            if (done === 1'b1) begin
                done_cnt++;
                if (cycles_to_done < 0) cycles_to_done = cyc;
            end
            if (cycles_to_done >= 0 && cyc >= cycles_to_done + 3) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        timed_out = !finished;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; limit = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({prime_out, out_valid, busy, done, prime_count} !== '0) begin
            bad++;
            $display("FAIL reset_state: got po=%0d v=%b busy=%b done=%b cnt=%0d, want all 0",
                     prime_out, out_valid, busy, done, prime_count);
        end
    endtask

    task automatic test_basic();
        exp_q = '{8'd2, 8'd3, 8'd5, 8'd7};
        out_ready = 1'b1;
        pulse_start(8'd7);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        collect(0, 2000);
        total++;
        if (timed_out) begin bad++; $display("FAIL basic_timeout: no done within budget"); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL basic_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL basic_val[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        total++;
        if (prime_count !== 8'd4) begin bad++; $display("FAIL basic_count: got %0d want 4", prime_count); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_limit_low();
        for (int l = 1; l >= 0; l--) begin
            out_ready = 1'b1;
            pulse_start(WIDTH'(l));
            collect(0, 20);
            total++;
            if (got_q.size() != 0) begin bad++; $display("FAIL low%0d_stream: got %0d values want 0", l, got_q.size()); end
            total++;
            if (done_cnt != 1) begin bad++; $display("FAIL low%0d_done: got %0d pulses want 1", l, done_cnt); end
            total++;
            if (cycles_to_done < 0 || cycles_to_done > 3) begin
                bad++; $display("FAIL low%0d_latency: got %0d cycles want <=3", l, cycles_to_done);
            end
            total++;
            if (prime_count !== 8'd0) begin bad++; $display("FAIL low%0d_count: got %0d want 0", l, prime_count); end
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL low%0d_busy: got %b want 0", l, busy); end
        end
    endtask

    task automatic test_backpressure();
        exp_q = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19, 8'd23, 8'd29};
        out_ready = 1'b0;
        pulse_start(8'd30);
        collect(1, 8000);
        total++;
        if (timed_out) begin bad++; $display("FAIL bp_timeout: no done within budget"); end
        total++;
        if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", unstable); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL bp_val[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (prime_count !== 8'd10) begin bad++; $display("FAIL bp_count: got %0d want 10", prime_count); end
    endtask

    task automatic test_full_range();
        exp_q.delete();
        for (int v = 2; v <= 255; v++) if (is_prime_ref(v)) exp_q.push_back(WIDTH'(v));
        out_ready = 1'b1;
        pulse_start(8'd255);
        collect(0, 60000);
        total++;
        if (timed_out) begin bad++; $display("FAIL full_timeout: no done within budget"); end
        total++;
        if (got_q.size() != 54) begin bad++; $display("FAIL full_len: got %0d want 54", got_q.size()); end
        total++;
        if (got_q.size() == 0 || got_q[got_q.size()-1] !== 8'd251) begin
            bad++; $display("FAIL full_last: got %0d want 251", got_q.size() ? got_q[got_q.size()-1] : 0);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL full_val[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL full_done: got %0d pulses want 1", done_cnt); end
        total++;
        if (prime_count !== 8'd54) begin bad++; $display("FAIL full_count: got %0d want 54", prime_count); end
    endtask

    task automatic test_start_ignored();
        bit found;
        exp_q = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19, 8'd23, 8'd29};
        out_ready = 1'b0;
        pulse_start(8'd30);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid === 1'b1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL ign_first_valid: out_valid never rose"); end
        total++;
        if (prime_out !== 8'd2) begin bad++; $display("FAIL ign_first: got %0d want 2", prime_out); end
        limit = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || prime_out !== 8'd2 || busy !== 1'b1) begin
            bad++; $display("FAIL ign_hold: got v=%b po=%0d busy=%b want v=1 po=2 busy=1",
                            out_valid, prime_out, busy);
        end
        collect(0, 5000);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL ign_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ign_val[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (prime_count !== 8'd10) begin bad++; $display("FAIL ign_count: got %0d want 10", prime_count); end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        exp_q = '{8'd2, 8'd3, 8'd5, 8'd7};
        out_ready = 1'b1;
        pulse_start(8'd100);
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (out_valid === 1'b1 && prime_out === 8'd13) begin found = 1'b1; break; end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (!found) begin bad++; $display("FAIL rstmid_reach13: prime 13 never presented"); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || prime_count !== 8'd0 || done !== 1'b0) begin
            bad++; $display("FAIL rstmid_state: got v=%b busy=%b cnt=%0d done=%b want 0 0 0 0",
                            out_valid, busy, prime_count, done);
        end
        rst = 1'b0;
        pulse_start(8'd7);
        collect(0, 2000);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rstmid_len: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rstmid_val[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
            end
        end
        total++;
        if (prime_count !== 8'd4) begin bad++; $display("FAIL rstmid_count: got %0d want 4", prime_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limit_low();
        test_backpressure();
        test_full_range();
        test_start_ignored();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
